// File: rtl/guineveer_sram_arb_pkg.sv
// Shared types and width helpers for the SRAM arbiter and its response-index FIFO.
package guineveer_sram_arb_pkg;

    localparam int MAX_NUM_REQ = 8;
    localparam int REQ_IDX_W   = $clog2(MAX_NUM_REQ);

    typedef logic [REQ_IDX_W-1:0] req_idx_t;

    // Pointer width that stays legal for a depth of one.
    function automatic int clog2_min1(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/guineveer_sram_arb_fifo.sv
// In-order FIFO of requester indices for granted memory requests awaiting a response.
module guineveer_sram_arb_fifo
    import guineveer_sram_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int WIDTH = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         push_i,
    input  logic [WIDTH-1:0]             data_i,
    input  logic                         pop_i,
    output logic [WIDTH-1:0]             data_o,
    output logic                         full_o,
    output logic                         empty_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int PTR_W = clog2_min1(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;
    logic             do_push, do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rd_ptr_q];
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= next_ptr(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= next_ptr(rd_ptr_q);
            if (do_push && !do_pop) begin
                count_q <= count_q + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count_q <= count_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/guineveer_sram_arb.sv
// Round-robin arbiter funnelling several requesters onto one SRAM port, routing
// in-order responses back to the requester that issued each request.
module guineveer_sram_arb
    import guineveer_sram_arb_pkg::*;
#(
    parameter int NUM_REQ         = 2,
    parameter int ADDR_WIDTH      = 32,
    parameter int DATA_WIDTH      = 64,
    parameter int MAX_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    input  logic [NUM_REQ-1:0]                     req_i,
    output logic [NUM_REQ-1:0]                     gnt_o,
    input  logic [NUM_REQ-1:0][ADDR_WIDTH-1:0]     addr_i,
    input  logic [NUM_REQ-1:0]                     we_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH/8-1:0]   strb_i,
    input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]     wdata_i,
    output logic [NUM_REQ-1:0]                     rvalid_o,
    output logic [DATA_WIDTH-1:0]                  rdata_o,
    output logic                                   mem_req_o,
    input  logic                                   mem_gnt_i,
    output logic [ADDR_WIDTH-1:0]                  mem_addr_o,
    output logic                                   mem_we_o,
    output logic [DATA_WIDTH/8-1:0]                mem_strb_o,
    output logic [DATA_WIDTH-1:0]                  mem_wdata_o,
    input  logic                                   mem_rvalid_i,
    input  logic [DATA_WIDTH-1:0]                  mem_rdata_i,
    output logic                                   busy_o,
    output logic                                   err_o
);

    localparam int CNT_W = $clog2(MAX_OUTSTANDING+1);

    req_idx_t         ptr_q, lock_idx_q, rr_sel, sel, head_idx, hi_sel, lo_sel;
    logic             lock_valid_q, err_q, hi_found;
    logic             handshake, pop, fifo_full, fifo_empty;
    logic [CNT_W-1:0] fifo_count;

    // Handshake: a transfer happens in any cycle where mem_req_o and mem_gnt_i are
    // both high; requesters hold req_i and payload until their gnt_o pulses.
    assign mem_req_o = rst_ni && (|req_i) && !fifo_full;
    assign handshake = mem_req_o && mem_gnt_i;
    assign pop       = mem_rvalid_i && !fifo_empty;
    assign busy_o    = rst_ni && ((fifo_count != '0) || (|req_i));
    assign err_o     = err_q;
    assign sel       = lock_valid_q ? lock_idx_q : rr_sel;

    // First active index at or above the pointer, else the lowest active index.
    always_comb begin
        hi_sel   = '0;
        lo_sel   = '0;
        hi_found = 1'b0;
        for (int i = NUM_REQ-1; i >= 0; i--) begin
            if (req_i[i]) begin
                lo_sel = req_idx_t'(i);
                if (req_idx_t'(i) >= ptr_q) begin
                    hi_sel   = req_idx_t'(i);
                    hi_found = 1'b1;
                end
            end
        end
        rr_sel = hi_found ? hi_sel : lo_sel;
    end

    always_comb begin
        mem_addr_o  = '0;
        mem_we_o    = 1'b0;
        mem_strb_o  = '0;
        mem_wdata_o = '0;
        gnt_o       = '0;
        rvalid_o    = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (mem_req_o && (sel == req_idx_t'(i))) begin
                mem_addr_o  = addr_i[i];
                mem_we_o    = we_i[i];
                mem_strb_o  = strb_i[i];
                mem_wdata_o = wdata_i[i];
            end
            gnt_o[i]    = handshake && (sel == req_idx_t'(i));
            rvalid_o[i] = pop && (head_idx == req_idx_t'(i));
        end
        rdata_o = pop ? mem_rdata_i : '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ptr_q        <= '0;
            lock_valid_q <= 1'b0;
            lock_idx_q   <= '0;
            err_q        <= 1'b0;
        end else begin
            err_q <= mem_rvalid_i && fifo_empty;
            if (handshake) begin
                ptr_q        <= (sel == req_idx_t'(NUM_REQ-1)) ? '0 : sel + req_idx_t'(1);
                lock_valid_q <= 1'b0;
            end else if (mem_req_o) begin
                // Memory stalled: freeze the winner so the request stays stable.
                lock_valid_q <= 1'b1;
                lock_idx_q   <= sel;
            end
        end
    end

    guineveer_sram_arb_fifo #(
        .DEPTH (MAX_OUTSTANDING),
        .WIDTH (REQ_IDX_W)
    ) u_idx_fifo (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .push_i  (handshake),
        .data_i  (sel),
        .pop_i   (pop),
        .data_o  (head_idx),
        .full_o  (fifo_full),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

endmodule
